// File: rtl/apple_vid_shifter_if.sv
// Read-side bus between the video shifter and its two memories:
// the 64-byte line buffer and the character ROM. Both return data one
// clk after their address is presented.
interface apple_vid_shifter_if;
  logic [5:0] buf_rd_addr;
  logic [7:0] buf_rd_data;
  logic [8:0] font_addr;
  logic [6:0] font_data;

  modport master (
    output buf_rd_addr,
    input  buf_rd_data,
    output font_addr,
    input  font_data
  );

  modport slave (
    input  buf_rd_addr,
    output buf_rd_data,
    input  font_addr,
    output font_data
  );
endinterface

// File: rtl/apple_vid_shifter.sv
// Apple-style video dot shifter. Reads the 40 prefetched bytes of a scan
// line, converts text through the character ROM, and serialises each byte
// into 14 monochrome dots on the dot enable (text, lo-res, hi-res).
// The fetch of byte n+1 overlaps the shifting of byte n.
module apple_vid_shifter (
  input  logic                       clk,
  input  logic                       RESET_N,
  input  logic                       pix_en,
  input  logic                       line_start,
  input  logic [1:0]                 mode,
  input  logic [2:0]                 row,
  input  logic                       lores_hi,
  input  logic                       flash,
  apple_vid_shifter_if.master        bus,
  output logic                       pix_out,
  output logic                       pix_valid
);

  localparam logic [5:0] LAST_COL = 6'd39;
  localparam logic [3:0] LAST_DOT = 4'd13;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_DOT = 3'd2,
    S_SHIFT    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // Byte fetch pipeline: C0 address, C1 byte/font address, C2 word build.
  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_C0   = 2'd1,
    F_C1   = 2'd2,
    F_C2   = 2'd3
  } fstage_t;

  state_t      state_r;
  fstage_t     f_stage_r;
  logic [1:0]  mode_r;
  logic [2:0]  row_r;
  logic        lores_hi_r;
  logic [5:0]  col_r;        // column currently being shifted out
  logic [5:0]  fcol_r;       // column being fetched
  logic [3:0]  idx_r;        // next dot index within cur_r
  logic [7:0]  byte_r;
  logic [13:0] next_r;       // next-byte word, bit d = dot d
  logic        ready_r;
  logic [13:0] cur_r;        // word being shifted out
  logic [5:0]  buf_rd_addr_r;
  logic [8:0]  font_addr_r;
  logic        pix_out_r;
  logic        pix_valid_r;

  logic [13:0] word_s;
  logic [13:0] hires_s;
  logic        inv_s;
  logic        prev_dot_s;

  // Each source bit becomes two identical dots.
  function automatic logic [13:0] dbl7(input logic [6:0] b);
    return {b[6], b[6], b[5], b[5], b[4], b[4], b[3], b[3],
            b[2], b[2], b[1], b[1], b[0], b[0]};
  endfunction

  // Lo-res: dot d = n[(d + 2*odd) mod 4]; odd columns use the nibble
  // rotated by two so the colour phase stays continuous across bytes.
  function automatic logic [13:0] lores_word(input logic [3:0] n, input logic odd);
    logic [3:0] r;
    if (odd) begin
      r = {n[1], n[0], n[3], n[2]};
    end else begin
      r = n;
    end
    return {r[1:0], r, r, r};
  endfunction

  // cur_r is cleared at line start, so column 0 sees a previous dot of 0.
  assign prev_dot_s = cur_r[13];

  // Build the 14-dot word for the byte in fetch stage C2.
  always_comb begin
    word_s  = 14'd0;
    hires_s = 14'd0;
    inv_s   = 1'b0;
    case (mode_r)
      2'b00: begin
        inv_s  = (byte_r[7:6] == 2'b00) | ((byte_r[7:6] == 2'b01) & flash);
        word_s = dbl7(bus.font_data) ^ {14{inv_s}};
      end
      2'b01: begin
        if (lores_hi_r) begin
          word_s = lores_word(byte_r[7:4], fcol_r[0]);
        end else begin
          word_s = lores_word(byte_r[3:0], fcol_r[0]);
        end
      end
      2'b10: begin
        hires_s = dbl7(byte_r[6:0]);
        if (byte_r[7]) begin
          word_s = {hires_s[12:0], prev_dot_s};
        end else begin
          word_s = hires_s;
        end
      end
      default: word_s = 14'd0;
    endcase
  end

  // Line sequencer: overlapped byte fetch plus the dot shifter.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r       <= S_IDLE;
      f_stage_r     <= F_IDLE;
      mode_r        <= 2'd0;
      row_r         <= 3'd0;
      lores_hi_r    <= 1'b0;
      col_r         <= 6'd0;
      fcol_r        <= 6'd0;
      idx_r         <= 4'd0;
      byte_r        <= 8'd0;
      next_r        <= 14'd0;
      ready_r       <= 1'b0;
      cur_r         <= 14'd0;
      buf_rd_addr_r <= 6'd0;
      font_addr_r   <= 9'd0;
      pix_out_r     <= 1'b0;
      pix_valid_r   <= 1'b0;
    end else if (line_start) begin
      // Any line in progress is abandoned; fetch of column 0 begins.
      mode_r     <= mode;
      row_r      <= row;
      lores_hi_r <= lores_hi;
      col_r      <= 6'd0;
      fcol_r     <= 6'd0;
      idx_r      <= 4'd0;
      cur_r      <= 14'd0;
      ready_r    <= 1'b0;
      f_stage_r  <= F_C0;
      state_r    <= S_FETCH;
    end else begin
      case (f_stage_r)
        F_C0: begin
          buf_rd_addr_r <= fcol_r;
          f_stage_r     <= F_C1;
        end
        F_C1: begin
          byte_r      <= bus.buf_rd_data;
          font_addr_r <= {bus.buf_rd_data[5:0], row_r};
          f_stage_r   <= F_C2;
        end
        F_C2: begin
          next_r    <= word_s;
          ready_r   <= 1'b1;
          f_stage_r <= F_IDLE;
          if (state_r == S_FETCH) begin
            state_r <= S_WAIT_DOT;
          end
        end
        default: f_stage_r <= F_IDLE;
      endcase

      if (pix_en) begin
        case (state_r)
          S_WAIT_DOT: begin
            if (ready_r) begin
              pix_out_r   <= next_r[0];
              pix_valid_r <= 1'b1;
              cur_r       <= next_r;
              ready_r     <= 1'b0;
              idx_r       <= 4'd1;
              state_r     <= S_SHIFT;
              fcol_r      <= 6'd1;
              f_stage_r   <= F_C0;
            end else begin
              pix_out_r   <= 1'b0;
              pix_valid_r <= 1'b0;
            end
          end
          S_SHIFT: begin
            pix_out_r   <= cur_r[idx_r];
            pix_valid_r <= 1'b1;
            if (idx_r == LAST_DOT) begin
              idx_r <= 4'd0;
              if (col_r == LAST_COL) begin
                state_r <= S_DONE;
              end else begin
                col_r   <= col_r + 6'd1;
                ready_r <= 1'b0;
                // A missing next byte shifts out as blank dots.
                cur_r   <= ready_r ? next_r : 14'd0;
              end
            end else begin
              idx_r <= idx_r + 4'd1;
              if ((idx_r == 4'd0) && (col_r != LAST_COL)) begin
                fcol_r    <= col_r + 6'd1;
                f_stage_r <= F_C0;
              end
            end
          end
          S_DONE: begin
            pix_out_r   <= 1'b0;
            pix_valid_r <= 1'b0;
            state_r     <= S_IDLE;
          end
          default: begin
            pix_out_r   <= 1'b0;
            pix_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.buf_rd_addr = buf_rd_addr_r;
  assign bus.font_addr   = font_addr_r;
  assign pix_out         = pix_out_r;
  assign pix_valid       = pix_valid_r;

endmodule
